// File: rtl/nonce_scan.sv
// nonce_scan: reads back NUM_NONCES H0 words, finds the first word below target and the minimum H0, writes a 2-word record.
// Optional build macro NONCE_SCAN_EARLY_EXIT_EN: stop issuing reads at the first hit.
module nonce_scan #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] h0_addr,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic [31:0]       target,
  output logic              done,
  output logic              found,
  output logic [31:0]       golden_nonce,
  output logic [31:0]       min_h0,
  output logic [31:0]       min_nonce,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

`ifdef NONCE_SCAN_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WR_GOLD,
    S_WR_MIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_res;
  logic [DW-1:0]     r_target;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_tag;
  logic              r_vld;

  logic              r_done;
  logic              r_found;
  logic [DW-1:0]     r_golden;
  logic [DW-1:0]     r_min_h0;
  logic [DW-1:0]     r_min_nonce;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DW-1:0]     r_mem_write_data;

  logic              w_hit;
  logic              w_lower;
  logic [DW-1:0]     w_tag32;
  logic              w_found_nx;
  logic [DW-1:0]     w_golden_nx;
  logic [DW-1:0]     w_min_nx;
  logic [DW-1:0]     w_min_nonce_nx;
  logic [IDX_W-1:0]  w_idx_inc;

  // Compare the word returned for the previous cycle's read; forwarded so record writes see it.
  always_comb begin
    w_hit          = r_vld && !r_found && (mem_read_data < r_target);
    w_lower        = r_vld && (mem_read_data < r_min_h0);
    w_tag32        = {{(DW-IDX_W){1'b0}}, r_tag};
    w_found_nx     = r_found | w_hit;
    w_golden_nx    = w_hit ? w_tag32 : r_golden;
    w_min_nx       = w_lower ? mem_read_data : r_min_h0;
    w_min_nonce_nx = w_lower ? w_tag32 : r_min_nonce;
    w_idx_inc      = r_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nx = S_READ;
      S_READ: begin
        // On an early exit the in-flight read is compared during WR_GOLD.
        if (EARLY_EXIT && w_hit)    w_state_nx = S_WR_GOLD;
        else if (r_idx == LAST_IDX) w_state_nx = S_DRAIN;
      end
      S_DRAIN:   w_state_nx = S_WR_GOLD;
      S_WR_GOLD: w_state_nx = S_WR_MIN;
      S_WR_MIN:  w_state_nx = S_DONE;
      S_DONE:    w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base           <= '0;
      r_res            <= '0;
      r_target         <= '0;
      r_idx            <= '0;
      r_tag            <= '0;
      r_vld            <= 1'b0;
      r_done           <= 1'b0;
      r_found          <= 1'b0;
      r_golden         <= '1;
      r_min_h0         <= '1;
      r_min_nonce      <= '0;
      r_mem_we         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
    end else begin
      r_vld    <= (r_state == S_READ);
      r_tag    <= r_idx;
      r_done   <= (w_state_nx == S_DONE);
      r_mem_we <= 1'b0;

      if (r_state == S_IDLE && start) begin
        r_base      <= h0_addr;
        r_res       <= result_addr;
        r_target    <= target;
        r_idx       <= '0;
        r_found     <= 1'b0;
        r_golden    <= '1;
        r_min_h0    <= '1;
        r_min_nonce <= '0;
        r_mem_addr  <= h0_addr;
      end else begin
        r_found     <= w_found_nx;
        r_golden    <= w_golden_nx;
        r_min_h0    <= w_min_nx;
        r_min_nonce <= w_min_nonce_nx;
      end

      if (r_state == S_READ && w_state_nx == S_READ) begin
        r_idx      <= w_idx_inc;
        r_mem_addr <= r_base + ADDR_W'(w_idx_inc);
      end

      if (w_state_nx == S_WR_GOLD) begin
        r_mem_we         <= 1'b1;
        r_mem_addr       <= r_res;
        r_mem_write_data <= w_golden_nx;
      end

      if (w_state_nx == S_WR_MIN) begin
        r_mem_we         <= 1'b1;
        r_mem_addr       <= r_res + ADDR_W'(1);
        r_mem_write_data <= w_min_nx;
      end
    end
  end

  assign done           = r_done;
  assign found          = r_found;
  assign golden_nonce   = r_golden;
  assign min_h0         = r_min_h0;
  assign min_nonce      = r_min_nonce;
  assign mem_clk        = clk;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_nonce_scan.sv
// Scoreboard bench for nonce_scan: directed memory images, expected records queued at start, checked on done.
module tb_nonce_scan;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 16;

`ifdef NONCE_SCAN_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] h0_addr;
  logic [AW-1:0] result_addr;
  logic [31:0]   target;
  logic          done;
  logic          found;
  logic [31:0]   golden_nonce;
  logic [31:0]   min_h0;
  logic [31:0]   min_nonce;
  logic          mem_clk;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  always #5 clk = ~clk;

  nonce_scan #(.NUM_NONCES(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .h0_addr(h0_addr),
    .result_addr(result_addr), .target(target), .done(done), .found(found),
    .golden_nonce(golden_nonce), .min_h0(min_h0), .min_nonce(min_nonce),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [31:0] mem [0:65535];

  // Single-port memory: one-cycle read latency, write on mem_we.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  typedef struct {
    logic        found;
    logic [31:0] golden;
    logic [31:0] min_h0;
    logic [31:0] min_nonce;
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int cyc      = 0;
  int t_start  = 0;
  int wr_count = 0;
  int n_done   = 0;
  int win_cnt  = 0;
  bit win_en   = 1'b0;
  int n_checks = 0;
  int n_err    = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we === 1'b1) wr_count <= wr_count + 1;
  always @(negedge clk)
    if (win_en && mem_addr >= 16'd1005 && mem_addr <= 16'd1015) win_cnt <= win_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic f, input logic [31:0] g, input logic [31:0] m,
                              input logic [31:0] mn, input logic [15:0] r, input int l);
    exp_t e;
    e.found = f; e.golden = g; e.min_h0 = m; e.min_nonce = mn; e.res = r; e.lat = l;
    return e;
  endfunction

  // Monitor: pop one expected record per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [15:0] r1;
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        r1 = mon_e.res + 16'd1;
        chk("found", 32'(found), 32'(mon_e.found));
        chk("golden_nonce", golden_nonce, mon_e.golden);
        chk("min_h0", min_h0, mon_e.min_h0);
        chk("min_nonce", min_nonce, mon_e.min_nonce);
        chk("mem_result0", mem[mon_e.res], mon_e.golden);
        chk("mem_result1", mem[r1], mon_e.min_h0);
        chk("latency", 32'(cyc - t_start + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic run_scan(input logic [15:0] h0, input logic [15:0] res, input logic [31:0] tgt,
                          input exp_t e, input bit poke);
    int nd0;
    int w0;
    bit seen;
    @(negedge clk);
    h0_addr = h0; result_addr = res; target = tgt; start = 1'b1;
    t_start = cyc + 1;
    nd0 = n_done;
    w0 = wr_count;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; h0_addr = h0 + 16'd50; target = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (n_done != nd0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (!seen) sb.delete();
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("write_count", 32'(wr_count - w0), 32'd2);
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [31:0] d);
    mem[a] <= d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0;
    int w0;
    reset = 1'b1; start = 1'b0; h0_addr = '0; result_addr = '0; target = '0;

    for (int a = 0; a < 65536; a++) set_mem(16'(a), 32'h0);
    for (int i = 0; i < 16; i++) begin
      set_mem(16'(2000 + i), 32'(32'h10000000 * (i + 1)));  // H0[15] wraps to 0
      set_mem(16'(100 + i), 32'hFFFFFFFF);
      set_mem(16'(500 + i), 32'h90000000 + 32'(i * 256));
      set_mem(16'(700 + i), 32'hFFFFFFFF);
      set_mem(16'hFFF8 + 16'(i), 32'h70000000 - 32'(i * 256));
      set_mem(16'(1000 + i), 32'hFFFFFFFF);
    end
    set_mem(16'd111, 32'h00000042);
    set_mem(16'd113, 32'h00000042);
    set_mem(16'd509, 32'h00000007);
    set_mem(16'd504, 32'h00000008);
    set_mem(16'hFFF7, 32'h0);
    set_mem(16'h0008, 32'h0);
    set_mem(16'd1003, 32'h00000005);
    set_mem(16'd4000, 32'hDEADBEEF);
    set_mem(16'd4001, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_golden", golden_nonce, 32'hFFFFFFFF);
    chk("rst_min_h0", min_h0, 32'hFFFFFFFF);
    chk("rst_min_nonce", min_nonce, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);

    // Ascending H0, first word wins
    run_scan(16'd2000, 16'd3000, 32'h35000000,
             EE ? mk(1'b1, 32'd0, 32'h10000000, 32'd0, 16'd3000, 5)
                : mk(1'b1, 32'd0, 32'h00000000, 32'd15, 16'd3000, 20), 1'b0);
    // Tie on minimum keeps the lower index
    run_scan(16'd100, 16'd200, 32'h00001000,
             mk(1'b1, 32'd11, 32'h42, 32'd11, 16'd200, EE ? 16 : 20), 1'b0);
    // target = 0: never found
    run_scan(16'd500, 16'd600, 32'h0,
             mk(1'b0, 32'hFFFFFFFF, 32'h7, 32'd9, 16'd600, 20), 1'b0);
    // All ones, strict compare against all-ones target
    run_scan(16'd700, 16'd800, 32'hFFFFFFFF,
             mk(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 16'd800, 20), 1'b0);
    // Read and result addresses wrap
    run_scan(16'hFFF8, 16'hFFFF, 32'h6FFFF500,
             EE ? mk(1'b1, 32'd12, 32'h6FFFF300, 32'd13, 16'hFFFF, 17)
                : mk(1'b1, 32'd12, 32'h6FFFF100, 32'd15, 16'hFFFF, 20), 1'b0);
    // Hit at index 3, watch the issued read window
    win_en = 1'b1;
    run_scan(16'd1000, 16'd1100, 32'h00001000,
             mk(1'b1, 32'd3, 32'h5, 32'd3, 16'd1100, EE ? 8 : 20), 1'b0);
    win_en = 1'b0;
    chk("addr_window_hit", 32'(win_cnt != 0), EE ? 32'd0 : 32'd1);

    // Reset on READ cycle 6 aborts the scan without writes
    @(negedge clk);
    h0_addr = 16'd500; result_addr = 16'd4000; target = 32'h0; start = 1'b1;
    nd0 = n_done;
    w0 = wr_count;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_golden", golden_nonce, 32'hFFFFFFFF);
    chk("abort_min_h0", min_h0, 32'hFFFFFFFF);
    chk("abort_min_nonce", min_nonce, 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(n_done - nd0), 32'd0);
    chk("abort_no_writes", 32'(wr_count - w0), 32'd0);
    chk("abort_mem4000", mem[16'd4000], 32'hDEADBEEF);

    // Restart with new data, with a start pulse while busy
    set_mem(16'd111, 32'hFFFFFFFF);
    set_mem(16'd113, 32'h00000042);
    set_mem(16'd114, 32'h00000041);
    run_scan(16'd100, 16'd4000, 32'h00001000,
             mk(1'b1, 32'd13, 32'h41, 32'd14, 16'd4000, EE ? 18 : 20), 1'b1);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
